stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state changes on the rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset; the same net drives the stack-pointer counter preload.
REQ-003 SHALL have port PUSH_REQ, input, 1, push request, level, sampled only in IDLE.
REQ-004 SHALL have port POP_REQ, input, 1, pop request, level, sampled only in IDLE.
REQ-005 SHALL have port DIN, input, 4, push data, captured in the request-accept cycle.
REQ-006 SHALL have port CLR_ERR, input, 1, synchronous clear of ERR.
REQ-007 SHALL have port DOUT, output, 4, pop data; holds until the next pop completes.
REQ-008 SHALL have port BUSY, output, 1, high in every state except IDLE.
REQ-009 SHALL have port DONE, output, 1, one-cycle pulse on operation completion.
REQ-010 SHALL have port FULL, output, 1, high when occupancy = 256.
REQ-011 SHALL have port EMPTY, output, 1, high when occupancy = 0.
REQ-012 SHALL have port DEPTH, output, 9, current occupancy 0..256.
REQ-013 SHALL have port ERR, output, 1, sticky overflow/underflow flag.
REQ-014 SHALL have port nSK_EN, output, 1, active-low stack datapath enable.
REQ-015 SHALL have port SP_D_nU, output, 1, 1 = push (write, count down), 0 = pop (read, count up).
REQ-016 SHALL have port SPC, output, 1, stack-pointer count pulse.
REQ-017 SHALL have port STOREBUS, inout, 4, stack data bus; driven only when nSK_EN=0 and SP_D_nU=1, otherwise high-Z.

Function
REQ-018 SHALL implement states IDLE, PSH_SET, PSH_WR, PSH_STEP, POP_STEP, POP_RD, POP_CAP, FIN.
REQ-019 IDLE: PUSH_REQ=1 SHALL transition to PSH_SET; otherwise POP_REQ=1 SHALL transition to POP_STEP; push wins when both requests are high.
REQ-020 PSH_SET and PSH_WR SHALL assert nSK_EN=0 and SP_D_nU=1, and SHALL drive the latched DIN on STOREBUS.
REQ-021 PSH_STEP SHALL hold the PSH_WR outputs and SHALL set SPC=1; the next state is FIN.
REQ-022 POP_STEP SHALL assert nSK_EN=0, SP_D_nU=0 and SPC=1.
REQ-023 POP_RD SHALL set SPC=0 and keep nSK_EN=0.
REQ-024 POP_CAP SHALL register STOREBUS into DOUT; the next state is FIN.
REQ-025 FIN SHALL pulse DONE=1, set nSK_EN=1, set SPC=0, update DEPTH (push +1, pop -1), and return to IDLE.
REQ-026 Latency SHALL be exactly 4 cycles from the accept edge to DONE for both push and pop; an op completes every 5 cycles while a request is held.
REQ-027 SP_D_nU SHALL hold its last value in IDLE/FIN, so direction never changes while SPC=1.
REQ-028 FULL, EMPTY and DEPTH SHALL be registered and SHALL update in the same cycle as DONE.
REQ-029 CLR_ERR SHALL clear ERR; if an error event coincides with CLR_ERR, ERR SHALL be 1.

Reset
REQ-030 RST=0 SHALL asynchronously force IDLE, nSK_EN=1, SP_D_nU=0, SPC=0, BUSY=0, DONE=0, DOUT=0, DEPTH=0, EMPTY=1, FULL=0, ERR=0 and STOREBUS high-Z.
REQ-031 Reset mid-operation SHALL abort the operation with no DONE and no DEPTH change; the pointer preloads to 0xFF on the same RST.

Configuration
REQ-032 Macro STACK_CTRL_GUARD_EN defined: PUSH_REQ with FULL=1, or POP_REQ with EMPTY=1 (when selected per REQ-019), SHALL go directly to FIN with no nSK_EN/SPC activity, SHALL set ERR=1, SHALL pulse DONE, and SHALL leave DEPTH and DOUT unchanged.
REQ-033 Macro undefined: no guard; the operation SHALL execute normally, the pointer wraps, DEPTH SHALL wrap modulo 512 (push at 256 gives 257, pop at 0 gives 511), and ERR SHALL be tied 0.

Verification
REQ-034 Reset, then PUSH_REQ pulse with DIN=0xA -> nSK_EN low for cycles 1-3, SPC high in cycle 3 only, DONE in cycle 4, DEPTH=1, EMPTY=0.
REQ-035 Push 0x3 then 0x7, then pop twice -> DOUT=0x7 then 0x3, DEPTH=0, EMPTY=1, STOREBUS high-Z during pops.
REQ-036 PUSH_REQ and POP_REQ both high in IDLE with DEPTH=5 -> push executes first, DEPTH=6, then pop executes.
REQ-037 Guard on: 256 pushes -> FULL=1; a 257th push -> no SPC pulse, ERR=1, DONE pulses; CLR_ERR=1 -> ERR=0.
REQ-038 RST low during PSH_WR -> outputs at reset values immediately, no DONE, DEPTH=0 after release.

Source files
------------

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencer for an external LIFO datapath (pointer counter + storage
// on a shared 4-bit bus). It tracks occupancy and reports completion.
// Optional build macro STACK_CTRL_GUARD_EN: refuse pushes when full and pops
// when empty, and flag them on the sticky ERR output.
module stack_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PUSH_REQ,
  input  logic       POP_REQ,
  input  logic [3:0] DIN,
  input  logic       CLR_ERR,
  output logic [3:0] DOUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       FULL,
  output logic       EMPTY,
  output logic [8:0] DEPTH,
  output logic       ERR,
  output logic       nSK_EN,
  output logic       SP_D_nU,
  output logic       SPC,
  inout  wire  [3:0] STOREBUS
);

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned DEPTH_W = 9;
  localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(256);

  typedef enum logic [2:0] {
    IDLE, PSH_SET, PSH_WR, PSH_STEP, POP_STEP, POP_RD, POP_CAP, FIN
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                nsk_en_q, nsk_en_d;
  logic                sp_d_nu_q, sp_d_nu_d;
  logic                spc_q, spc_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                drive_q, drive_d;
`ifdef STACK_CTRL_GUARD_EN
  logic                err_q, err_d;
  logic                guard_c;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      din_q     <= '0;
      dout_q    <= '0;
      depth_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      nsk_en_q  <= 1'b1;
      sp_d_nu_q <= 1'b0;
      spc_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      drive_q   <= 1'b0;
`ifdef STACK_CTRL_GUARD_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      depth_q   <= depth_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      nsk_en_q  <= nsk_en_d;
      sp_d_nu_q <= sp_d_nu_d;
      spc_q     <= spc_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      drive_q   <= drive_d;
`ifdef STACK_CTRL_GUARD_EN
      err_q     <= err_d;
`endif
    end
  end

  // Next state, datapath updates, and outputs decoded from the state being entered
  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    dout_d    = dout_q;
    depth_d   = depth_q;
`ifdef STACK_CTRL_GUARD_EN
    guard_c   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (PUSH_REQ) begin
          din_d   = DIN;
          state_d = PSH_SET;
`ifdef STACK_CTRL_GUARD_EN
          if (full_q) begin
            state_d = FIN;
            guard_c = 1'b1;
          end
`endif
        end else if (POP_REQ) begin
          state_d = POP_STEP;
`ifdef STACK_CTRL_GUARD_EN
          if (empty_q) begin
            state_d = FIN;
            guard_c = 1'b1;
          end
`endif
        end
      end
      PSH_SET:  state_d = PSH_WR;
      PSH_WR:   state_d = PSH_STEP;
      PSH_STEP: begin
        state_d = FIN;
        depth_d = depth_q + DEPTH_W'(1);
      end
      POP_STEP: state_d = POP_RD;
      POP_RD:   state_d = POP_CAP;
      POP_CAP: begin
        state_d = FIN;
        dout_d  = STOREBUS;
        depth_d = depth_q - DEPTH_W'(1);
      end
      FIN:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    full_d    = (depth_d == MAX_DEPTH);
    empty_d   = (depth_d == '0);

    nsk_en_d  = 1'b1;
    spc_d     = 1'b0;
    drive_d   = 1'b0;
    sp_d_nu_d = sp_d_nu_q;
    done_d    = (state_d == FIN);
    busy_d    = (state_d != IDLE);
    case (state_d)
      PSH_SET, PSH_WR: begin
        nsk_en_d  = 1'b0;
        sp_d_nu_d = 1'b1;
        drive_d   = 1'b1;
      end
      PSH_STEP: begin
        nsk_en_d  = 1'b0;
        sp_d_nu_d = 1'b1;
        drive_d   = 1'b1;
        spc_d     = 1'b1;
      end
      POP_STEP: begin
        nsk_en_d  = 1'b0;
        sp_d_nu_d = 1'b0;
        spc_d     = 1'b1;
      end
      POP_RD, POP_CAP: begin
        nsk_en_d  = 1'b0;
        sp_d_nu_d = 1'b0;
      end
      default: ;
    endcase

`ifdef STACK_CTRL_GUARD_EN
    // Error event wins over a coincident clear
    err_d = (err_q & ~CLR_ERR) | guard_c;
`endif
  end

  assign DOUT     = dout_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign FULL     = full_q;
  assign EMPTY    = empty_q;
  assign DEPTH    = depth_q;
  assign nSK_EN   = nsk_en_q;
  assign SP_D_nU  = sp_d_nu_q;
  assign SPC      = spc_q;
  assign STOREBUS = drive_q ? din_q : {DATA_W{1'bz}};

`ifdef STACK_CTRL_GUARD_EN
  assign ERR = err_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = CLR_ERR;
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed checks of stack_ctrl against a model of the external
// stack (pointer preloaded to 0xFF, push writes then counts down, pop counts up
// then reads). The bus has pull-ups so an undriven bus reads 0xF.
module tb_stack_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PUSH_REQ = 1'b0;
  logic       POP_REQ = 1'b0;
  logic [3:0] DIN = 4'h0;
  logic       CLR_ERR = 1'b0;
  logic [3:0] DOUT;
  logic       BUSY, DONE, FULL, EMPTY, ERR, nSK_EN, SP_D_nU, SPC;
  logic [8:0] DEPTH;
  wire  [3:0] STOREBUS;

  int checks = 0;
  int passed = 0;

  stack_ctrl dut (
    .CLK(CLK), .RST(RST), .PUSH_REQ(PUSH_REQ), .POP_REQ(POP_REQ), .DIN(DIN),
    .CLR_ERR(CLR_ERR), .DOUT(DOUT), .BUSY(BUSY), .DONE(DONE), .FULL(FULL),
    .EMPTY(EMPTY), .DEPTH(DEPTH), .ERR(ERR), .nSK_EN(nSK_EN), .SP_D_nU(SP_D_nU),
    .SPC(SPC), .STOREBUS(STOREBUS)
  );

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup pu (STOREBUS[g]);
  end

  // External stack model: pointer counter and storage
  logic [3:0] mem [256];
  logic [7:0] sp;
  always @(posedge CLK or negedge RST) begin
    if (!RST) sp <= 8'hFF;
    else begin
      if (!nSK_EN && SP_D_nU && !SPC) mem[sp] <= STOREBUS;
      if (SPC) sp <= SP_D_nU ? sp - 8'd1 : sp + 8'd1;
    end
  end
  assign STOREBUS = (!nSK_EN && !SP_D_nU) ? mem[sp] : 4'bzzzz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  task tick;
    @(posedge CLK);
    #1;
  endtask

  task reset_dut;
    RST = 1'b0; PUSH_REQ = 1'b0; POP_REQ = 1'b0; CLR_ERR = 1'b0;
    tick; tick;
    RST = 1'b1;
    tick;
  endtask

  // Starts one op from IDLE, waits for DONE (bounded), returns in IDLE
  task automatic do_op(input logic push, input logic [3:0] d, output bit ok);
    PUSH_REQ = push; POP_REQ = !push; DIN = d;
    tick;
    PUSH_REQ = 1'b0; POP_REQ = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (DONE) ok = 1'b1;
      else tick;
    end
    tick;
  endtask

  task automatic test_reset;
    logic [7:0] flags;
    #3 RST = 1'b0;
    #1;
    flags = {BUSY, DONE, nSK_EN, SP_D_nU, SPC, FULL, EMPTY, ERR};
    checks++; if (flags !== 8'b0010_0010) $display("FAIL reset_async_flags: got %b want 00100010", flags); else passed++;
    checks++; if (DEPTH !== 9'd0) $display("FAIL reset_depth: got %0d want 0", DEPTH); else passed++;
    checks++; if (DOUT !== 4'h0) $display("FAIL reset_dout: got %h want 0", DOUT); else passed++;
    checks++; if (STOREBUS !== 4'hF) $display("FAIL reset_bus_hiz: got %h want F (pulled up)", STOREBUS); else passed++;
    tick; tick;
    RST = 1'b1;
    tick; tick;
    flags = {BUSY, DONE, nSK_EN, SP_D_nU, SPC, FULL, EMPTY, ERR};
    checks++; if (flags !== 8'b0010_0010) $display("FAIL reset_idle_flags: got %b want 00100010", flags); else passed++;
  endtask

  task automatic test_push_single;
    logic [4:0] want_v [5] = '{5'b00011, 5'b00011, 5'b01011, 5'b10111, 5'b10001};
    logic [4:0] obs;
    PUSH_REQ = 1'b1; DIN = 4'hA;
    tick;
    PUSH_REQ = 1'b0; DIN = 4'h0;
    for (int c = 1; c <= 5; c++) begin
      obs = {nSK_EN, SPC, DONE, BUSY, SP_D_nU};
      checks++; if (obs !== want_v[c-1]) $display("FAIL push_seq_c%0d {nSK_EN,SPC,DONE,BUSY,SP_D_nU}: got %b want %b", c, obs, want_v[c-1]); else passed++;
      if (c <= 2) begin
        checks++; if (STOREBUS !== 4'hA) $display("FAIL push_bus_c%0d: got %h want A", c, STOREBUS); else passed++;
      end
      if (c == 3) begin
        checks++; if (DEPTH !== 9'd0) $display("FAIL push_depth_early: got %0d want 0", DEPTH); else passed++;
      end
      if (c == 4) begin
        checks++; if (DEPTH !== 9'd1 || EMPTY !== 1'b0) $display("FAIL push_depth_done: got depth=%0d empty=%b want 1/0", DEPTH, EMPTY); else passed++;
      end
      tick;
    end
  endtask

  task automatic test_lifo;
    logic [4:0] want_v [5] = '{5'b01010, 5'b00010, 5'b00010, 5'b10110, 5'b10000};
    logic [4:0] obs;
    bit ok1, ok2;
    reset_dut;
    do_op(1'b1, 4'h3, ok1);
    do_op(1'b1, 4'h7, ok2);
    checks++; if (!(ok1 && ok2) || DEPTH !== 9'd2) $display("FAIL lifo_pushes: got ok=%b%b depth=%0d want 11/2", ok1, ok2, DEPTH); else passed++;
    POP_REQ = 1'b1;
    tick;
    POP_REQ = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      obs = {nSK_EN, SPC, DONE, BUSY, SP_D_nU};
      checks++; if (obs !== want_v[c-1]) $display("FAIL pop_seq_c%0d {nSK_EN,SPC,DONE,BUSY,SP_D_nU}: got %b want %b", c, obs, want_v[c-1]); else passed++;
      if (c == 2) begin
        checks++; if (STOREBUS !== 4'h7) $display("FAIL pop_bus_read: got %h want 7", STOREBUS); else passed++;
      end
      if (c == 3) begin
        checks++; if (DOUT !== 4'h0) $display("FAIL pop_dout_early: got %h want 0", DOUT); else passed++;
      end
      if (c == 4) begin
        checks++; if (DOUT !== 4'h7 || DEPTH !== 9'd1) $display("FAIL pop1_result: got dout=%h depth=%0d want 7/1", DOUT, DEPTH); else passed++;
      end
      tick;
    end
    tick; tick;
    checks++; if (DOUT !== 4'h7) $display("FAIL pop_dout_hold: got %h want 7", DOUT); else passed++;
    do_op(1'b0, 4'h0, ok1);
    checks++; if (!ok1 || DOUT !== 4'h3 || DEPTH !== 9'd0 || EMPTY !== 1'b1)
      $display("FAIL pop2_result: got ok=%b dout=%h depth=%0d empty=%b want 1/3/0/1", ok1, DOUT, DEPTH, EMPTY);
    else passed++;
    checks++; if (STOREBUS !== 4'hF) $display("FAIL idle_bus_hiz: got %h want F", STOREBUS); else passed++;
  endtask

  task automatic test_both_req;
    bit ok, all_ok;
    reset_dut;
    all_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      do_op(1'b1, 4'(i), ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok || DEPTH !== 9'd5) $display("FAIL both_setup: got ok=%b depth=%0d want 1/5", all_ok, DEPTH); else passed++;
    PUSH_REQ = 1'b1; POP_REQ = 1'b1; DIN = 4'h9;
    tick;
    PUSH_REQ = 1'b0;
    checks++; if (SP_D_nU !== 1'b1 || nSK_EN !== 1'b0) $display("FAIL both_push_first: got dir=%b nsk=%b want 1/0", SP_D_nU, nSK_EN); else passed++;
    tick; tick; tick;
    checks++; if (DONE !== 1'b1 || DEPTH !== 9'd6) $display("FAIL both_push_done: got done=%b depth=%0d want 1/6", DONE, DEPTH); else passed++;
    tick;
    checks++; if (BUSY !== 1'b0) $display("FAIL both_idle_gap: got busy=%b want 0", BUSY); else passed++;
    tick;
    POP_REQ = 1'b0;
    checks++; if (SP_D_nU !== 1'b0 || SPC !== 1'b1) $display("FAIL both_pop_next: got dir=%b spc=%b want 0/1", SP_D_nU, SPC); else passed++;
    tick; tick; tick;
    checks++; if (DONE !== 1'b1 || DEPTH !== 9'd5 || DOUT !== 4'h9)
      $display("FAIL both_pop_done: got done=%b depth=%0d dout=%h want 1/5/9", DONE, DEPTH, DOUT);
    else passed++;
    tick;
  endtask

  task automatic test_full_boundary;
    bit ok, all_ok, spc_seen, nsk_low;
    int done_at;
    reset_dut;
    all_ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      do_op(1'b1, 4'(i), ok);
      all_ok &= ok;
      if (i == 254) begin
        checks++; if (FULL !== 1'b0 || DEPTH !== 9'd255) $display("FAIL fill_255: got full=%b depth=%0d want 0/255", FULL, DEPTH); else passed++;
      end
    end
    checks++; if (!all_ok || FULL !== 1'b1 || DEPTH !== 9'd256 || EMPTY !== 1'b0)
      $display("FAIL fill_256: got ok=%b full=%b depth=%0d empty=%b want 1/1/256/0", all_ok, FULL, DEPTH, EMPTY);
    else passed++;
    PUSH_REQ = 1'b1; DIN = 4'hC;
    tick;
    PUSH_REQ = 1'b0;
    spc_seen = 1'b0; nsk_low = 1'b0; done_at = 0;
    for (int c = 1; c <= 6 && done_at == 0; c++) begin
      spc_seen |= SPC;
      nsk_low  |= !nSK_EN;
      if (DONE) done_at = c;
      else tick;
    end
`ifdef STACK_CTRL_GUARD_EN
    checks++; if (done_at != 1 || spc_seen || nsk_low)
      $display("FAIL guard_push_fast: got done_at=%0d spc=%b nsk_low=%b want 1/0/0", done_at, spc_seen, nsk_low);
    else passed++;
    checks++; if (ERR !== 1'b1 || DEPTH !== 9'd256 || FULL !== 1'b1)
      $display("FAIL guard_push_state: got err=%b depth=%0d full=%b want 1/256/1", ERR, DEPTH, FULL);
    else passed++;
    tick; tick;
    checks++; if (ERR !== 1'b1) $display("FAIL guard_err_sticky: got %b want 1", ERR); else passed++;
    CLR_ERR = 1'b1;
    tick;
    CLR_ERR = 1'b0;
    checks++; if (ERR !== 1'b0) $display("FAIL guard_clr_err: got %b want 0", ERR); else passed++;
    reset_dut;
    POP_REQ = 1'b1; CLR_ERR = 1'b1;
    tick;
    POP_REQ = 1'b0; CLR_ERR = 1'b0;
    checks++; if (ERR !== 1'b1 || DONE !== 1'b1 || DEPTH !== 9'd0 || DOUT !== 4'h0)
      $display("FAIL guard_pop_empty: got err=%b done=%b depth=%0d dout=%h want 1/1/0/0", ERR, DONE, DEPTH, DOUT);
    else passed++;
    tick;
`else
    checks++; if (done_at != 4 || !spc_seen || !nsk_low)
      $display("FAIL wrap_push_exec: got done_at=%0d spc=%b nsk_low=%b want 4/1/1", done_at, spc_seen, nsk_low);
    else passed++;
    checks++; if (DEPTH !== 9'd257 || FULL !== 1'b0 || ERR !== 1'b0)
      $display("FAIL wrap_push_state: got depth=%0d full=%b err=%b want 257/0/0", DEPTH, FULL, ERR);
    else passed++;
    tick;
    do_op(1'b0, 4'h0, ok);
    checks++; if (!ok || DOUT !== 4'hC || DEPTH !== 9'd256 || FULL !== 1'b1)
      $display("FAIL wrap_pop: got ok=%b dout=%h depth=%0d full=%b want 1/C/256/1", ok, DOUT, DEPTH, FULL);
    else passed++;
    reset_dut;
    do_op(1'b0, 4'h0, ok);
    checks++; if (!ok || DEPTH !== 9'd511 || EMPTY !== 1'b0 || ERR !== 1'b0)
      $display("FAIL wrap_pop_empty: got ok=%b depth=%0d empty=%b err=%b want 1/511/0/0", ok, DEPTH, EMPTY, ERR);
    else passed++;
`endif
  endtask

  task automatic test_reset_midop;
    bit ok, done_seen;
    logic [4:0] obs;
    reset_dut;
    do_op(1'b1, 4'h5, ok);
    checks++; if (!ok || DEPTH !== 9'd1) $display("FAIL midop_setup: got ok=%b depth=%0d want 1/1", ok, DEPTH); else passed++;
    PUSH_REQ = 1'b1; DIN = 4'h6;
    tick;
    PUSH_REQ = 1'b0;
    tick;
    RST = 1'b0;
    #1;
    obs = {BUSY, DONE, nSK_EN, SP_D_nU, SPC};
    checks++; if (obs !== 5'b00100) $display("FAIL midop_async: got {BUSY,DONE,nSK_EN,SP_D_nU,SPC}=%b want 00100", obs); else passed++;
    checks++; if (DEPTH !== 9'd0 || EMPTY !== 1'b1 || STOREBUS !== 4'hF)
      $display("FAIL midop_state: got depth=%0d empty=%b bus=%h want 0/1/F", DEPTH, EMPTY, STOREBUS);
    else passed++;
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; done_seen |= DONE; end
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin tick; done_seen |= DONE; end
    checks++; if (done_seen || DEPTH !== 9'd0 || BUSY !== 1'b0)
      $display("FAIL midop_after: got done_seen=%b depth=%0d busy=%b want 0/0/0", done_seen, DEPTH, BUSY);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_push_single;
    test_lifo;
    test_both_req;
    test_full_boundary;
    test_reset_midop;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
